icache_fill_ctrl: RTL and testbench

//  Instruction-cache miss/refill controller in the Fetch stage, directly upstream of hazard_unit.

---
 rtl/icache_fill_ctrl_if.sv | 37 +++
 rtl/icache_fill_ctrl.sv | 121 ++++++++++++
 tb/tb_icache_fill_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction-cache refill controller.
// master: the controller; slave: the surrounding fetch stage / memory model.
interface icache_fill_ctrl_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned IdxW = $clog2(LINE_WORDS);

    logic [ADDR_W-1:0] PCF;
    logic              LookupValidF;
    logic              HitF;
    logic              InstrMissF;
    logic              InstrCacheRepActive;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemReady;
    logic              MemRValid;
    logic [DATA_W-1:0] MemRData;
    logic              FillWe;
    logic [IdxW-1:0]   FillWordIdx;
    logic [DATA_W-1:0] FillData;
    logic              TagWe;
    logic [ADDR_W-1:0] LineAddr;

    modport master (
        input  PCF, LookupValidF, HitF, MemReady, MemRValid, MemRData,
        output InstrMissF, InstrCacheRepActive, MemReq, MemAddr,
               FillWe, FillWordIdx, FillData, TagWe, LineAddr
    );

    modport slave (
        output PCF, LookupValidF, HitF, MemReady, MemRValid, MemRData,
        input  InstrMissF, InstrCacheRepActive, MemReq, MemAddr,
               FillWe, FillWordIdx, FillData, TagWe, LineAddr
    );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss/refill controller: one burst read per missing line, words written
// as beats arrive, tag committed in a single DONE cycle that also bypasses the new line.
module icache_fill_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input logic                clk,
    input logic                reset_n,
    icache_fill_ctrl_if.master bus
);
    localparam int unsigned IdxW  = $clog2(LINE_WORDS);
    localparam int unsigned OffW  = IdxW + 2;
    localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((64'd1 << OffW) - 64'd1);
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StFill, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;

    logic              miss;
    logic              done_miss;
    logic [ADDR_W-1:0] pc_line;
    logic [DATA_W-1:0] fill_data;

    assign miss      = bus.LookupValidF & ~bus.HitF;
    assign pc_line   = bus.PCF & ~OffMask;
    // Freshly filled line is not yet readable from the array, so match it here.
    assign done_miss = bus.LookupValidF & ~(bus.HitF | (pc_line == line_addr_q));
    assign fill_data = bus.MemRData;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            line_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            line_addr_q <= line_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_addr_d = line_addr_q;
        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    line_addr_d = pc_line;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (bus.MemReady) begin
                    beat_cnt_d = '0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (bus.MemRValid) begin
                    beat_cnt_d = beat_cnt_q + IdxW'(1);
                    if (beat_cnt_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (done_miss) begin
                    line_addr_d = pc_line;
                    state_d     = StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.InstrMissF          = 1'b0;
        bus.InstrCacheRepActive = 1'b0;
        bus.MemReq              = 1'b0;
        bus.MemAddr             = '0;
        bus.FillWe              = 1'b0;
        bus.FillWordIdx         = '0;
        bus.FillData            = '0;
        bus.TagWe               = 1'b0;
        bus.LineAddr            = line_addr_q;
        unique case (state_q)
            StIdle: bus.InstrMissF = miss;
            StReq: begin
                bus.InstrMissF = 1'b1;
                bus.MemReq     = 1'b1;
                bus.MemAddr    = line_addr_q;
            end
            StFill: begin
                bus.InstrMissF = 1'b1;
                if (bus.MemRValid) begin
                    bus.FillWe      = 1'b1;
                    bus.FillWordIdx = beat_cnt_q;
                    bus.FillData    = fill_data;
                end
            end
            StDone: begin
                bus.TagWe               = 1'b1;
                bus.InstrCacheRepActive = 1'b1;
                bus.InstrMissF          = done_miss;
            end
            default: ;
        endcase
        // IDLE decodes the miss combinationally, so reset must mask it explicitly.
        if (!reset_n) begin
            bus.InstrMissF = 1'b0;
            bus.LineAddr   = '0;
        end
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl; fill beats are checked against a scoreboard queue
// filled as beats are driven.
module tb_icache_fill_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    icache_fill_ctrl_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) bus ();

    icache_fill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          tag_cnt = 0;
    int          hs_cnt = 0;
    int          fill_idx = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        bus.MemRValid = 1'b1;
        bus.MemRData  = d;
        exp_q.push_back({32'(fill_idx), d});
        fill_idx = (fill_idx + 1) % 4;
        tick();
        bus.MemRValid = 1'b0;
        bus.MemRData  = '0;
    endtask

    // Monitor: pops one expected beat per FillWe, counts tag writes and request handshakes.
    always @(negedge clk) begin
        if (bus.TagWe === 1'b1) tag_cnt++;
        if (bus.MemReq === 1'b1 && bus.MemReady === 1'b1) hs_cnt++;
        if (bus.FillWe === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("fill_unexpected", 64'(bus.FillWe), 64'(0));
            end else begin
                exp_e = exp_q.pop_front();
                chk("fill_beat", {32'(bus.FillWordIdx), 32'(bus.FillData)}, exp_e);
            end
        end
    end

    initial begin
        bus.PCF          = '0;
        bus.LookupValidF = 1'b0;
        bus.HitF         = 1'b0;
        bus.MemReady     = 1'b0;
        bus.MemRValid    = 1'b0;
        bus.MemRData     = '0;
        #3;
        chk("rst_missf", 64'(bus.InstrMissF), 64'(0));
        chk("rst_memreq", 64'(bus.MemReq), 64'(0));
        chk("rst_tagwe", 64'(bus.TagWe), 64'(0));
        chk("rst_lineaddr", 64'(bus.LineAddr), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();

        // Hit and no-lookup produce no miss.
        bus.LookupValidF = 1'b1; bus.HitF = 1'b1; bus.PCF = 32'h0000_1000;
        #1;
        chk("hit_missf", 64'(bus.InstrMissF), 64'(0));
        tick();
        chk("hit_no_req", 64'(bus.MemReq), 64'(0));
        bus.LookupValidF = 1'b0; bus.HitF = 1'b0;
        #1;
        chk("novalid_missf", 64'(bus.InstrMissF), 64'(0));
        tick();
        chk("novalid_no_req", 64'(bus.MemReq), 64'(0));

        // Miss at 0x1044, request held two cycles, stray beats in REQ ignored.
        bus.LookupValidF = 1'b1; bus.PCF = 32'h0000_1044;
        #1;
        chk("miss_same_cycle", 64'(bus.InstrMissF), 64'(1));
        chk("miss_no_req_yet", 64'(bus.MemReq), 64'(0));
        tick();
        chk("req1_memreq", 64'(bus.MemReq), 64'(1));
        chk("req1_addr", 64'(bus.MemAddr), 64'h1040);
        chk("req1_missf", 64'(bus.InstrMissF), 64'(1));
        bus.MemRValid = 1'b1; bus.MemRData = 32'hDEAD_BEEF;
        #1;
        chk("req_beat_no_we", 64'(bus.FillWe), 64'(0));
        tick();
        chk("req2_memreq", 64'(bus.MemReq), 64'(1));
        chk("req2_addr", 64'(bus.MemAddr), 64'h1040);
        bus.MemRValid = 1'b0; bus.MemRData = '0;
        bus.MemReady = 1'b1;
        tick();
        bus.MemReady = 1'b0;
        chk("fill_no_req", 64'(bus.MemReq), 64'(0));
        chk("fill_missf", 64'(bus.InstrMissF), 64'(1));
        fill_idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                #1;
                chk("gap_no_we", 64'(bus.FillWe), 64'(0));
                tick();
            end
            beat(32'hA000_0000 + 32'(i));
        end
        chk("done_tagwe", 64'(bus.TagWe), 64'(1));
        chk("done_rep", 64'(bus.InstrCacheRepActive), 64'(1));
        chk("done_bypass_missf", 64'(bus.InstrMissF), 64'(0));
        chk("done_lineaddr", 64'(bus.LineAddr), 64'h1040);
        bus.LookupValidF = 1'b0;
        tick();
        chk("idle_no_tagwe", 64'(bus.TagWe), 64'(0));

        // Redirect to 0x3000 mid-fill; DONE re-requests for the new line.
        bus.LookupValidF = 1'b1; bus.PCF = 32'h0000_104C;
        #1;
        chk("miss2_missf", 64'(bus.InstrMissF), 64'(1));
        tick();
        bus.MemReady = 1'b1;
        #1;
        chk("req3_addr", 64'(bus.MemAddr), 64'h1040);
        tick();
        bus.MemReady = 1'b0;
        fill_idx = 0;
        beat(32'hB000_0000);
        beat(32'hB000_0001);
        bus.PCF = 32'h0000_3000;
        beat(32'hB000_0002);
        beat(32'hB000_0003);
        chk("redir_tagwe", 64'(bus.TagWe), 64'(1));
        chk("redir_rep", 64'(bus.InstrCacheRepActive), 64'(1));
        chk("redir_missf", 64'(bus.InstrMissF), 64'(1));
        chk("redir_lineaddr", 64'(bus.LineAddr), 64'h1040);
        tick();
        chk("redir_req", 64'(bus.MemReq), 64'(1));
        chk("redir_addr", 64'(bus.MemAddr), 64'h3000);
        chk("redir_new_line", 64'(bus.LineAddr), 64'h3000);
        bus.MemReady = 1'b1;
        tick();
        bus.MemReady = 1'b0;
        fill_idx = 0;
        for (int i = 0; i < 4; i++) beat(32'hC000_0000 + 32'(i));

        // Back-to-back miss from DONE to 0x2008.
        bus.PCF = 32'h0000_2008; bus.HitF = 1'b0;
        #1;
        chk("b2b_missf", 64'(bus.InstrMissF), 64'(1));
        chk("b2b_rep", 64'(bus.InstrCacheRepActive), 64'(1));
        tick();
        chk("b2b_req", 64'(bus.MemReq), 64'(1));
        chk("b2b_addr", 64'(bus.MemAddr), 64'h2000);
        chk("b2b_keep_missf", 64'(bus.InstrMissF), 64'(1));
        bus.MemReady = 1'b1;
        tick();
        bus.MemReady = 1'b0;
        fill_idx = 0;
        beat(32'hD000_0000);
        beat(32'hD000_0001);

        // Reset mid-fill after two beats.
        reset_n = 1'b0;
        #1;
        chk("mrst_missf", 64'(bus.InstrMissF), 64'(0));
        chk("mrst_memreq", 64'(bus.MemReq), 64'(0));
        chk("mrst_fillwe", 64'(bus.FillWe), 64'(0));
        chk("mrst_tagwe", 64'(bus.TagWe), 64'(0));
        chk("mrst_rep", 64'(bus.InstrCacheRepActive), 64'(0));
        chk("mrst_lineaddr", 64'(bus.LineAddr), 64'(0));
        tick();
        tick();
        chk("mrst_tag_count", 64'(tag_cnt), 64'(3));
        bus.LookupValidF = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("post_rst_missf", 64'(bus.InstrMissF), 64'(0));
        chk("post_rst_memreq", 64'(bus.MemReq), 64'(0));
        bus.LookupValidF = 1'b1; bus.HitF = 1'b0; bus.PCF = 32'h0000_4000;
        #1;
        chk("post_rst_idle_miss", 64'(bus.InstrMissF), 64'(1));
        tick();
        chk("post_rst_req", 64'(bus.MemReq), 64'(1));
        chk("post_rst_addr", 64'(bus.MemAddr), 64'h4000);
        chk("handshake_count", 64'(hs_cnt), 64'(4));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        chk("tag_count_final", 64'(tag_cnt), 64'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
